reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit pipeline register (test_module_0) among N_REQ write requesters. It accepts one valid/ready transfer at a time and issues a single-cycle write (load enable plus data) to the register. After each write it enforces a configurable lock-out window before it grants again. It sits directly in front of the register's data input and load enable.

Parameters:
WIDTH, 8, data width of each requester and of the shared register
N_REQ, 4, number of requesters (2..16)
HOLD_CYCLES, 2, idle cycles enforced after each write before the next grant (1..15)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_req_valid  input  N_REQ  per-requester write request
i_req_data  input  N_REQ*WIDTH  packed request data; requester k owns bits [k*WIDTH +: WIDTH]
o_req_ready  output  N_REQ  one-hot accept; a transfer occurs when valid[k]&ready[k]
o_reg_we  output  1  single-cycle load enable to shared register
o_reg_d  output  WIDTH  data to shared register, valid while o_reg_we=1
o_grant_id  output  clog2(N_REQ) (min 1)  index of last accepted requester
o_busy  output  1  high in WRITE or HOLD state

Behaviour:
- Reset: state=IDLE, rr pointer=N_REQ-1 (requester 0 has first priority), o_reg_we=0, o_reg_d=0, o_grant_id=0, o_busy=0, o_req_ready=0, hold counter=0. Reset mid-WRITE/HOLD drops the pending write; o_reg_we is 0 in the cycle after reset is sampled.
- FSM states: IDLE, WRITE, HOLD.
- IDLE: combinational round-robin selection. Search order is ptr+1, ptr+2, … mod N_REQ. The first requester with valid=1 wins and gets o_req_ready[k]=1 in the same cycle. All other ready bits are 0. If no valid is high, all ready bits are 0 and the FSM stays in IDLE.
- On transfer in IDLE: register the data into o_reg_d, set o_grant_id=k and ptr=k, and go to WRITE.
- WRITE (exactly 1 cycle): o_reg_we=1 and o_reg_d holds the accepted data. Next state is HOLD, with counter loaded to HOLD_CYCLES-1.
- HOLD: o_reg_we=0 and all ready bits are 0. The counter decrements each cycle. When counter==0, the FSM returns to IDLE.
- Latency: transfer edge to o_reg_we high is 1 cycle. Maximum accept rate is one transfer per 2+HOLD_CYCLES cycles.
- o_req_ready is 0 in every cycle outside IDLE. o_busy = (state!=IDLE).
- Requester rules: once valid is raised, it stays high with stable data until accepted. The arbiter never accepts a requester whose valid is low. Dropping valid before acceptance is legal; that requester is simply skipped.
- Simultaneous requests: exactly one ready bit per IDLE cycle. Fairness: a continuously requesting requester is granted within N_REQ grants.
- Wrap-around: pointer at N_REQ-1 searches from 0. A single requester may be granted back-to-back if it is the only one valid.
- o_reg_d and o_grant_id hold their last values until the next transfer. They do not clear after WRITE.
- A valid arriving during WRITE or HOLD waits and is arbitrated on the first IDLE cycle.

Test Plan:
1. Reset then single request: valid[0]=1, data[0]=0xA5 → ready[0]=1 in the first IDLE cycle; next cycle o_reg_we=1, o_reg_d=0xA5, o_grant_id=0; o_busy=1 for 1+2 cycles, then IDLE.
2. All four valid continuously, data k=0x10+k → grant order 0,1,2,3,0,…; o_reg_we pulses every 4 cycles; o_reg_d sequence 0x10,0x11,0x12,0x13,0x10.
3. Only requesters 1 and 3 valid, ptr=3 after reset sequence → grants 1,3,1,3; no ready pulse to 0 or 2.
4. Request arrives during HOLD (valid[2] raised the cycle after WRITE) → ready[2] stays 0 through HOLD and asserts on the first IDLE cycle; no o_reg_we during HOLD.
5. Assert i_rst in WRITE cycle → next cycle o_reg_we=0, o_busy=0, o_reg_d=0; a still-valid requester 0 is granted first after reset release.
6. HOLD_CYCLES=1, N_REQ=2 instance with both valid → o_reg_we period of 3 cycles; alternating grant ids 0,1,0,1.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared register: accepts a single valid/ready
// transfer, issues a one-cycle load, then enforces a lock-out before re-arbitrating.
module reg_write_arbiter #(
  parameter int WIDTH       = 8,
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_reg_we,
  output logic [WIDTH-1:0]       o_reg_d,
  output logic [IDW-1:0]         o_grant_id,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [IDW-1:0]   ptr;
  logic [3:0]       cnt, cnt_n;
  logic             sel_found;
  logic [IDW-1:0]   sel_idx;
  logic [IDW-1:0]   cand;
  logic [N_REQ-1:0] ready;
  logic             we;
  logic             accept;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDW'((int'(ptr) + i) % N_REQ);
      if (!sel_found && i_req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready   = '0;
    we      = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        // A grant raised while reset is sampled would be lost, so suppress it.
        if (sel_found && !i_rst) begin
          ready[sel_idx] = 1'b1;
          accept         = 1'b1;
          state_n        = WRITE;
        end
      end
      WRITE: begin
        we      = 1'b1;
        state_n = HOLD;
        cnt_n   = 4'(HOLD_CYCLES - 1);
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= IDW'(N_REQ - 1);
      cnt        <= '0;
      o_reg_d    <= '0;
      o_grant_id <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        o_reg_d    <= i_req_data[sel_idx*WIDTH +: WIDTH];
        o_grant_id <= sel_idx;
        ptr        <= sel_idx;
      end
    end
  end

  assign o_req_ready = ready;
  assign o_reg_we    = we;
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: constant vector table, directed
// sequences and randomized traffic against a cycle-count based reference model.
module tb_reg_write_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int H = 2;

  logic           clk;
  logic           i_rst;
  logic [N-1:0]   valid;
  logic [N*W-1:0] data;
  logic [N-1:0]   ready;
  logic           we;
  logic [W-1:0]   reg_d;
  logic [1:0]     gid;
  logic           busy;

  logic [1:0]     valid2;
  logic [2*W-1:0] data2;
  logic [1:0]     ready2;
  logic           we2;
  logic [W-1:0]   reg_d2;
  logic [0:0]     gid2;
  logic           busy2;

  reg_write_arbiter #(.WIDTH(W), .N_REQ(N), .HOLD_CYCLES(H)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(ready), .o_reg_we(we), .o_reg_d(reg_d), .o_grant_id(gid), .o_busy(busy)
  );

  reg_write_arbiter #(.WIDTH(W), .N_REQ(2), .HOLD_CYCLES(1)) u_dut2 (
    .i_clk(clk), .i_rst(i_rst), .i_req_valid(valid2), .i_req_data(data2),
    .o_req_ready(ready2), .o_reg_we(we2), .o_reg_d(reg_d2), .o_grant_id(gid2), .o_busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   rdy;
    logic           we;
    logic [W-1:0]   rd;
    logic [1:0]     gid;
    logic           busy;
  } vec_t;

  typedef struct {
    int         c;
    logic [7:0] d;
    int         g;
  } ev_t;

  vec_t vecs[7];
  ev_t  log_q[$];
  ev_t  log2[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Reference model state: time-based view of when the arbiter may grant again.
  int         m_ptr;
  int         m_next_idle;
  int         m_last;
  logic [7:0] m_d;
  int         m_grant;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_ptr       = N - 1;
    m_next_idle = cyc;
    m_last      = -100;
    m_d         = '0;
    m_grant     = 0;
  endtask

  task automatic do_reset();
    i_rst  = 1'b1;
    valid  = '0;
    valid2 = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    i_rst = 1'b0;
    model_reset();
    log_q.delete();
  endtask

  task automatic apply_stimulus(input logic [N-1:0] v, input logic [N*W-1:0] d);
    valid = v;
    data  = d;
    @(negedge clk);
  endtask

  task automatic check_output(input vec_t e);
    check("tbl_ready", 32'(ready), 32'(e.rdy));
    check("tbl_we",    32'(we),    32'(e.we));
    check("tbl_d",     32'(reg_d), 32'(e.rd));
    check("tbl_gid",   32'(gid),   32'(e.gid));
    check("tbl_busy",  32'(busy),  32'(e.busy));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle against the model: grants only after the lock-out has elapsed,
  // searching upward from the previous winner with wrap-around.
  task automatic run_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, output int win);
    int k;
    logic [N-1:0] exp_ready;
    ev_t ev;
    apply_stimulus(v, d);
    win = -1;
    if (cyc >= m_next_idle) begin
      for (int i = 1; i <= N; i++) begin
        k = (m_ptr + i) % N;
        if (v[k] && win < 0) win = k;
      end
    end
    exp_ready = (win >= 0) ? (N'(1) << win) : '0;
    check("ready", 32'(ready), 32'(exp_ready));
    check("we",    32'(we),    32'(cyc == m_last + 1));
    check("busy",  32'(busy),  32'(cyc > m_last && cyc < m_next_idle));
    check("reg_d", 32'(reg_d), 32'(m_d));
    check("gid",   32'(gid),   32'(m_grant));
    if (we) begin
      ev.c = cyc;
      ev.d = reg_d;
      ev.g = int'(gid);
      log_q.push_back(ev);
    end
    if (win >= 0) begin
      m_ptr       = win;
      m_grant     = win;
      m_d         = d[win*W +: W];
      m_last      = cyc;
      m_next_idle = cyc + 2 + H;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int win;
    logic [N-1:0]   rv;
    logic [N*W-1:0] rd;
    ev_t ev;

    vecs[0] = '{4'b0001, 32'h0000_00A5, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[1] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 8'hA5, 2'd0, 1'b1};
    vecs[2] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b1};
    vecs[3] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b1};
    vecs[4] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b0};
    vecs[5] = '{4'b0010, 32'h0000_3C00, 4'b0010, 1'b0, 8'hA5, 2'd0, 1'b0};
    vecs[6] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 8'h3C, 2'd1, 1'b1};

    i_rst  = 1'b1;
    valid  = '0;
    data   = '0;
    valid2 = '0;
    data2  = '0;

    $display("[TB] single request table");
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].v, vecs[i].d);
      check_output(vecs[i]);
    end

    $display("[TB] all requesters continuously valid");
    do_reset();
    for (int i = 0; i < 22; i++) run_cycle(4'b1111, 32'h1312_1110, win);
    check("rr_count", 32'(log_q.size() >= 5), 32'd1);
    if (log_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("rr_gid", 32'(log_q[i].g), 32'(i % 4));
        check("rr_d",   32'(log_q[i].d), 32'(8'h10 + 8'(i % 4)));
        if (i > 0) check("rr_period", 32'(log_q[i].c - log_q[i-1].c), 32'd4);
      end
    end

    $display("[TB] requesters 1 and 3 only");
    do_reset();
    for (int i = 0; i < 18; i++) run_cycle(4'b1010, 32'h3300_1100, win);
    check("odd_count", 32'(log_q.size() >= 4), 32'd1);
    if (log_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("odd_gid", 32'(log_q[i].g), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    $display("[TB] request raised during lock-out");
    do_reset();
    run_cycle(4'b0001, 32'h0000_0077, win);
    run_cycle(4'b0000, 32'h0000_0000, win);
    for (int i = 0; i < 4; i++) run_cycle(4'b0100, 32'h0099_0000, win);

    $display("[TB] reset during write");
    do_reset();
    run_cycle(4'b0001, 32'h0000_005A, win);
    valid = 4'b0001;
    i_rst = 1'b1;
    @(negedge clk);
    check("rst_write_we", 32'(we), 32'd1);
    @(posedge clk);
    #1;
    cyc++;
    i_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) run_cycle(4'b0001, 32'h0000_005A, win);

    $display("[TB] randomized traffic");
    do_reset();
    rv = '0;
    rd = '0;
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < N; k++) begin
        if (!rv[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            rv[k] = 1'b1;
            rd[k*W +: W] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          rv[k] = 1'b0;
        end
      end
      run_cycle(rv, rd, win);
      if (win >= 0) begin
        if ($urandom_range(0, 1) == 0) rv[win] = 1'b0;
        else rd[win*W +: W] = 8'($urandom);
      end
    end

    $display("[TB] two requesters, one lock-out cycle");
    do_reset();
    valid2 = 2'b11;
    data2  = 16'hB1B0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (we2) begin
        ev.c = cyc;
        ev.d = reg_d2;
        ev.g = int'(gid2);
        log2.push_back(ev);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    valid2 = '0;
    check("n2_count", 32'(log2.size() >= 4), 32'd1);
    if (log2.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("n2_gid", 32'(log2[i].g), 32'(i % 2));
        check("n2_d",   32'(log2[i].d), (i % 2 == 0) ? 32'hB0 : 32'hB1);
        if (i > 0) check("n2_period", 32'(log2[i].c - log2[i-1].c), 32'd3);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
